pipe_drawer: RTL and testbench

- Consumer of the pipe position stream (pipe x, top-of-opening y) produced by the pipe generator.
- On each position update, erases the pipe at its previous position, then draws it at the new position.
- Output is a one-pixel-per-cycle plot stream (x, y, colour, plot) into the VGA adapter, on the 160x120 frame.
- Provides busy/done status to the game controller.

---
 rtl/pipe_drawer.sv | 175 +++++++++++++++++
 tb/tb_pipe_drawer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_drawer.sv
// Pipe renderer: on each position update, repaints the old pipe in background
// colour, then draws the new pipe, one registered pixel per cycle.
module pipe_drawer #(
   parameter int         SCREEN_W    = 160,
   parameter int         SCREEN_H    = 120,
   parameter int         PIPE_W      = 4,
   parameter int         GAP_H       = 20,
   parameter logic [2:0] PIPE_COLOUR = 3'b010,
   parameter logic [2:0] BG_COLOUR   = 3'b000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       update,
   input  logic [7:0] pipe_x,
   input  logic [6:0] pipe_y,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   localparam int COL_W = (PIPE_W > 1) ? $clog2(PIPE_W) : 1;

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

   state_t           state_q, state_d;
   logic [7:0]       cur_x_q, cur_x_d;
   logic [6:0]       cur_y_q, cur_y_d;
   logic [7:0]       old_x_q, old_x_d;
   logic             old_valid_q, old_valid_d;
   logic [7:0]       pend_x_q, pend_x_d;
   logic [6:0]       pend_y_q, pend_y_d;
   logic             pend_valid_q, pend_valid_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [6:0]       row_q, row_d;
   logic [7:0]       vga_x_q, vga_x_d;
   logic [6:0]       vga_y_q, vga_y_d;
   logic [2:0]       colour_q, colour_d;
   logic             plot_q, plot_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [8:0]       px_x;
   logic [7:0]       row8, gap_lo, gap_hi;
   logic             in_gap, last_pix;

   // 9-bit x so columns past the right edge are clipped instead of wrapping.
   assign px_x     = {1'b0, (state_q == ERASE) ? old_x_q : cur_x_q} + 9'(col_q);
   assign row8     = {1'b0, row_q};
   assign gap_lo   = {1'b0, cur_y_q};
   assign gap_hi   = gap_lo + 8'(GAP_H);
   assign in_gap   = (row8 >= gap_lo) && (row8 < gap_hi);
   assign last_pix = (col_q == COL_W'(PIPE_W - 1)) && (row_q == 7'(SCREEN_H - 1));

   always_comb begin
      state_d      = state_q;
      cur_x_d      = cur_x_q;
      cur_y_d      = cur_y_q;
      old_x_d      = old_x_q;
      old_valid_d  = old_valid_q;
      pend_x_d     = pend_x_q;
      pend_y_d     = pend_y_q;
      pend_valid_d = pend_valid_q;
      col_d        = col_q;
      row_d        = row_q;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      colour_d     = colour_q;
      plot_d       = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;

      if (state_q != IDLE && update) begin
         pend_x_d     = pipe_x;
         pend_y_d     = pipe_y;
         pend_valid_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            // A pending position is served first; a simultaneous update queues behind it.
            if (pend_valid_q) begin
               cur_x_d      = pend_x_q;
               cur_y_d      = pend_y_q;
               pend_valid_d = update;
               if (update) begin
                  pend_x_d = pipe_x;
                  pend_y_d = pipe_y;
               end
            end else if (update) begin
               cur_x_d = pipe_x;
               cur_y_d = pipe_y;
            end
            if (pend_valid_q || update) begin
               state_d = old_valid_q ? ERASE : DRAW;
               col_d   = '0;
               row_d   = '0;
            end
         end
         ERASE, DRAW: begin
            vga_x_d  = px_x[7:0];
            vga_y_d  = row_q;
            colour_d = (state_q == ERASE || in_gap) ? BG_COLOUR : PIPE_COLOUR;
            plot_d   = (px_x < 9'(SCREEN_W));
            busy_d   = 1'b1;
            if (row_q == 7'(SCREEN_H - 1)) begin
               row_d = '0;
               col_d = col_q + COL_W'(1);
            end else begin
               row_d = row_q + 7'd1;
            end
            if (last_pix) begin
               col_d   = '0;
               row_d   = '0;
               state_d = (state_q == ERASE) ? DRAW : DONE;
            end
         end
         DONE: begin
            done_d      = 1'b1;
            old_x_d     = cur_x_q;
            old_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q      <= IDLE;
         cur_x_q      <= '0;
         cur_y_q      <= '0;
         old_x_q      <= '0;
         old_valid_q  <= 1'b0;
         pend_x_q     <= '0;
         pend_y_q     <= '0;
         pend_valid_q <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         colour_q     <= '0;
         plot_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         old_x_q      <= old_x_d;
         old_valid_q  <= old_valid_d;
         pend_x_q     <= pend_x_d;
         pend_y_q     <= pend_y_d;
         pend_valid_q <= pend_valid_d;
         col_q        <= col_d;
         row_q        <= row_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         colour_q     <= colour_d;
         plot_q       <= plot_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign vga_x  = vga_x_q;
   assign vga_y  = vga_y_q;
   assign colour = colour_q;
   assign plot   = plot_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_pipe_drawer.sv
// Directed bench for pipe_drawer: every plotted pixel is matched against an
// expected queue built from a small model of the erase/draw passes.
module tb_pipe_drawer;

   logic       clk = 1'b0;
   logic       resetn;
   logic       update;
   logic [7:0] pipe_x;
   logic [6:0] pipe_y;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] colour;
   logic       plot, busy, done;

   always #5 clk = ~clk;

   pipe_drawer dut (
      .CLOCK_50 (clk),
      .resetn   (resetn),
      .update   (update),
      .pipe_x   (pipe_x),
      .pipe_y   (pipe_y),
      .vga_x    (vga_x),
      .vga_y    (vga_y),
      .colour   (colour),
      .plot     (plot),
      .busy     (busy),
      .done     (done)
   );

   logic [17:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          plot_tot = 0;
   int          busy_tot = 0;
   int          done_tot = 0;
   bit          mon_chk = 1'b0;
   logic [7:0]  m_old_x = '0;
   bit          m_old_valid = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One pass of the model: column-major, clipped columns produce no plot.
   task automatic push_pass(input logic [7:0] bx, input logic [6:0] y, input bit erase);
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 120; r++) begin
            int         x;
            logic [2:0] col;
            x = int'(bx) + c;
            if (erase || (r >= int'(y) && r < int'(y) + 20)) col = 3'b000;
            else col = 3'b010;
            if (x < 160) exp_q.push_back({8'(x), 7'(r), col});
         end
      end
   endtask

   task automatic pulse(input logic [7:0] x, input logic [6:0] y);
      @(posedge clk); #1;
      update = 1'b1;
      pipe_x = x;
      pipe_y = y;
      @(posedge clk); #1;
      update = 1'b0;
   endtask

   task automatic run_update(input logic [7:0] x, input logic [6:0] y, input string tag);
      int n_exp, passes, cyc, p0, b0, d0;
      p0     = plot_tot;
      b0     = busy_tot;
      d0     = done_tot;
      passes = m_old_valid ? 2 : 1;
      n_exp  = exp_q.size();
      if (m_old_valid) push_pass(m_old_x, 7'd0, 1'b1);
      push_pass(x, y, 1'b0);
      n_exp       = exp_q.size() - n_exp;
      m_old_x     = x;
      m_old_valid = 1'b1;
      pulse(x, y);
      cyc = 1;
      while (done !== 1'b1 && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_latency"}, cyc, passes * 480 + 2);
      @(negedge clk); #1;
      check({tag, "_plots"}, plot_tot - p0, n_exp);
      check({tag, "_busy_cycles"}, busy_tot - b0, passes * 480);
      check({tag, "_done_pulses"}, done_tot - d0, 1);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      int p0, b0, d0, n_exp, cyc;
      logic [17:0] e;
      resetn = 1'b0;
      update = 1'b0;
      pipe_x = '0;
      pipe_y = '0;

      fork
         forever begin
            @(negedge clk);
            if (plot === 1'b1) plot_tot++;
            if (busy === 1'b1) busy_tot++;
            if (done === 1'b1) done_tot++;
            if (mon_chk && plot === 1'b1) begin
               checks++;
               assert (exp_q.size() != 0) else begin
                  errors++;
                  $error("FAIL unexpected_plot: observed x=%0d y=%0d c=%0d expected none", vga_x, vga_y, colour);
               end
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  checks++;
                  assert ({vga_x, vga_y, colour} === e) else begin
                     errors++;
                     $error("FAIL pixel: observed x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                            vga_x, vga_y, colour, e[17:10], e[9:3], e[2:0]);
                  end
               end
            end
         end
      join_none

      // Reset and idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_vga_x", vga_x, 0);
      check("rst_vga_y", vga_y, 0);
      check("rst_colour", colour, 0);
      check("rst_plot", plot, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(posedge clk); #1;
      resetn  = 1'b1;
      mon_chk = 1'b1;
      p0 = plot_tot; b0 = busy_tot; d0 = done_tot;
      repeat (10) @(posedge clk);
      @(negedge clk); #1;
      check("idle_plots", plot_tot - p0, 0);
      check("idle_busy", busy_tot - b0, 0);
      check("idle_done", done_tot - d0, 0);

      run_update(8'd100, 7'd50, "first");
      run_update(8'd99, 7'd30, "second");
      run_update(8'd158, 7'd110, "clip");

      // Three updates during one pass: only the last one is drawn afterwards.
      p0 = plot_tot; b0 = busy_tot; d0 = done_tot;
      n_exp = exp_q.size();
      push_pass(8'd158, 7'd0, 1'b1);
      push_pass(8'd120, 7'd10, 1'b0);
      push_pass(8'd120, 7'd0, 1'b1);
      push_pass(8'd70, 7'd80, 1'b0);
      n_exp   = exp_q.size() - n_exp;
      m_old_x = 8'd70;
      pulse(8'd120, 7'd10);
      repeat (50) @(posedge clk);
      pulse(8'd90, 7'd60);
      repeat (100) @(posedge clk);
      pulse(8'd80, 7'd70);
      repeat (100) @(posedge clk);
      pulse(8'd70, 7'd80);
      cyc = 0;
      while (done_tot - d0 < 2 && cyc < 5000) begin
         @(posedge clk); #1;
         cyc++;
      end
      repeat (20) @(posedge clk);
      @(negedge clk); #1;
      check("pend_done_pulses", done_tot - d0, 2);
      check("pend_plots", plot_tot - p0, n_exp);
      check("pend_busy_cycles", busy_tot - b0, 1920);
      check("pend_queue_empty", exp_q.size(), 0);

      // Reset in the middle of the draw pass.
      mon_chk = 1'b0;
      pulse(8'd10, 7'd5);
      repeat (600) @(posedge clk);
      #1 resetn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_plot", plot, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      exp_q.delete();
      m_old_valid = 1'b0;
      mon_chk     = 1'b1;
      repeat (5) @(posedge clk);
      run_update(8'd50, 7'd60, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
